uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the single UART transmitter among NUM_REQ byte requesters (e.g. RX echo path, btn1 message source).
// - Accepts one byte at a time via valid/ready, launches the transmitter with a 1-cycle tx_start pulse, and tracks tx_busy to completion.
// - Sits between the requesters and the UART TX serializer, in the same clock domain as the UART RX path.
// PARAMETERS
// - DATA_W       8   byte width per requester and on tx_data
// - NUM_REQ      2   number of requesters (2..8)
// - ACK_TIMEOUT  64  cycles to wait for tx_busy to rise after tx_start before aborting (>=2)
// PORTS
// - clk          in   1                  system clock, all logic on rising edge
// - reset_n      in   1                  asynchronous, active-low reset
// - req_valid    in   NUM_REQ            requester i has a byte to send
// - req_data     in   NUM_REQ*DATA_W     byte of requester i at [i*DATA_W +: DATA_W]
// - req_ready    out  NUM_REQ            one-hot accept; byte i is transferred when valid[i] & ready[i]
// - tx_start     out  1                  1-cycle launch pulse to the transmitter
// - tx_data      out  DATA_W             registered byte; held stable from tx_start until the return to IDLE
// - tx_busy      in   1                  transmitter serializing (high from the cycle after tx_start through the stop bit)
// - grant_id     out  $clog2(NUM_REQ)    index of the last accepted requester
// - arb_busy     out  1                  high in every state except IDLE
// - timeout_err  out  1                  1-cycle pulse when ACK_TIMEOUT expires
// BEHAVIOUR
// - Reset values: state=IDLE, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, timeout_err=0, rr pointer=NUM_REQ-1, ack counter=0.
// - req_ready is combinational: one-hot of the winner when state==IDLE, tx_busy==0, any valid and reset_n==1; otherwise all 0.
// - FSM IDLE:
//   - On accept in cycle N: capture req_data[winner] into tx_data, grant_id<=winner, go to LAUNCH.
//   - tx_busy==1 in IDLE blocks all acceptance.
// - FSM LAUNCH: tx_start=1 for exactly this cycle (N+1). Go to WAIT_ACK; ack counter<=0.
// - FSM WAIT_ACK:
//   - tx_busy==1 -> go to WAIT_DONE.
//   - Otherwise the counter increments. When counter==ACK_TIMEOUT-1 and tx_busy is still 0: pulse timeout_err, go to IDLE, drop the byte.
//   - tx_busy rising on the same cycle the counter expires: busy wins, go to WAIT_DONE with no error.
// - FSM WAIT_DONE: tx_busy==0 -> IDLE. The next accept is possible on the following cycle at the earliest.
// - Throughput: one byte per transmitter frame plus 3 cycles of overhead (accept, LAUNCH, WAIT_DONE exit).
// - A requester dropping valid before it is accepted is legal; no byte is captured. req_data is sampled only in the accept cycle.
// - Reset asserted mid-operation:
//   - All state clears asynchronously; tx_start drops immediately.
//   - An in-flight byte is lost; no timeout_err is emitted.
//   - req_ready is held 0 while reset_n is low.
// - The rr pointer updates only on accept (pointer<=winner). It is unaffected by timeouts or reset release.
// CONFIGURATION
// - UART_TX_ARB_ROUND_ROBIN_EN defined: round-robin. The search starts at pointer+1 and wraps modulo NUM_REQ, so the winner is the first valid index after the last grant.
// - UART_TX_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest valid index wins. The rr pointer logic is not built, and grant_id still reports the winner.
// TESTING
// - Single byte: req_valid=01, data0=8'hA5, model busy 1 cycle after start for 160 cycles
//   -> ready[0] one cycle, tx_start one pulse, tx_data=A5, arb_busy low 1 cycle after busy falls.
// - Contention, RR_EN defined: valid=11 held, data0=8'h11, data1=8'h22, 4 frames
//   -> tx_data sequence 11,22,11,22; grant_id 0,1,0,1. Without RR_EN -> 11,11,11,11.
// - Timeout: model never raises tx_busy, ACK_TIMEOUT=64
//   -> timeout_err pulses exactly 64 cycles after the WAIT_ACK entry, state returns to IDLE, next request accepted normally.
// - Busy blocking: tx_busy forced high while idle with valid=01
//   -> req_ready stays 0 and no tx_start until busy falls, then accept in the next cycle.
// - Reset mid-frame: assert reset_n=0 during WAIT_DONE
//   -> tx_start, arb_busy, timeout_err and req_ready all 0 immediately; after release, a fresh 8'h3C is sent correctly.
// - Boundary: tx_busy rising exactly in the timeout cycle -> no timeout_err, frame completes.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the UART TX serializer and uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 2
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [GW-1:0]             grant_id;
  logic                      arb_busy;
  logic                      timeout_err;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters: accept, launch, track tx_busy.
// Define UART_TX_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module uart_tx_arbiter #(
  parameter int DATA_W      = 8,
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset_n,
  uart_tx_arbiter_if.slave   bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] winner;
  logic          accept;
  logic          ack_expired;
  logic          timeout_fire;
  logic [CW-1:0] ack_cnt;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr;

  // Descending scan so the smallest offset after the last grant is the final assignment.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (bus.req_valid[idx]) winner = GW'(idx);
    end
  end
`else
  // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) winner = GW'(i);
    end
  end
`endif

  // reset_n gates the handshake directly so no byte can be offered while reset is held.
  assign accept      = (state == IDLE) && !bus.tx_busy && (|bus.req_valid) && reset_n;
  assign ack_expired = (ack_cnt == CW'(ACK_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.tx_busy)      state_nxt = WAIT_DONE;
        else if (ack_expired) state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
    bus.tx_start  = (state == LAUNCH);
    bus.arb_busy  = (state != IDLE);
    // A busy rising in the expiry cycle takes precedence over the timeout.
    timeout_fire  = (state == WAIT_ACK) && !bus.tx_busy && ack_expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.tx_data     <= '0;
      bus.grant_id    <= '0;
      bus.timeout_err <= 1'b0;
      ack_cnt         <= '0;
    end else begin
      bus.timeout_err <= timeout_fire;
      if (accept) begin
        bus.tx_data  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
        bus.grant_id <= winner;
      end
      if (state == LAUNCH)                      ack_cnt <= '0;
      else if (state == WAIT_ACK && !bus.tx_busy) ack_cnt <= ack_cnt + CW'(1);
    end
  end

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_ptr <= GW'(NUM_REQ - 1);
    else if (accept) rr_ptr <= winner;
  end
`endif

endmodule
